// File: rtl/mem_load_stage_pkg.sv
// Shared defines for the MEM load stage: datapath widths, load-FSM encoding
// and the one-hot l_mask bit positions.
package mem_load_stage_pkg;
  localparam int XLEN          = 32;
  localparam int RF_ADDR_WIDTH = 5;

  localparam int LM_W   = 5;
  localparam int LM_LB  = 0;
  localparam int LM_LH  = 1;
  localparam int LM_LW  = 2;
  localparam int LM_LBU = 3;
  localparam int LM_LHU = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } ld_state_e;
endpackage

// File: rtl/mem_load_stage_load_align.sv
// Combinational load-data extraction: picks the byte/halfword lane out of the
// captured bus word and sign- or zero-extends it according to l_mask.
module load_align #(
  parameter int XLEN = mem_load_stage_pkg::XLEN
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr_2low,
  input  logic [4:0]      l_mask,
  output logic [XLEN-1:0] data
);
  import mem_load_stage_pkg::*;

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = word[7:0];
    case (addr_2low)
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
  end

  assign h = addr_2low[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    if (l_mask[LM_LB])       data = {{(XLEN-8){b[7]}}, b};
    else if (l_mask[LM_LBU]) data = {{(XLEN-8){1'b0}}, b};
    else if (l_mask[LM_LH])  data = {{(XLEN-16){h[15]}}, h};
    else if (l_mask[LM_LHU]) data = {{(XLEN-16){1'b0}}, h};
  end
endmodule

// File: rtl/mem_load_stage.sv
// MEM pipeline stage: issues one data-bus read per aligned load, tolerates
// grant/response stalls and flushes, and registers the result into WB.
module mem_load_stage #(
  parameter int XLEN          = mem_load_stage_pkg::XLEN,
  parameter int RF_ADDR_WIDTH = mem_load_stage_pkg::RF_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pipe_flush,
  input  logic                     ex_mem_valid,
  output logic                     mem_allowin,
  input  logic [XLEN-1:0]          mem_pc,
  input  logic [XLEN-1:0]          mem_alu_res,
  input  logic                     mem_req_rf,
  input  logic [RF_ADDR_WIDTH-1:0] mem_rf_waddr,
  input  logic                     mem_is_load,
  input  logic [1:0]               mem_ls_addr_2low,
  input  logic [4:0]               mem_l_mask,
  output logic                     dbus_req,
  output logic [XLEN-1:0]          dbus_addr,
  input  logic                     dbus_gnt,
  input  logic                     dbus_rvalid,
  input  logic [XLEN-1:0]          dbus_rdata,
  input  logic                     wb_allowin,
  output logic                     mem_wb_valid,
  output logic [XLEN-1:0]          wb_pc,
  output logic [XLEN-1:0]          wb_wdata,
  output logic                     wb_req_rf,
  output logic [RF_ADDR_WIDTH-1:0] wb_rf_waddr,
  output logic                     wb_load_misal
);
  import mem_load_stage_pkg::*;

  ld_state_e       state_q, state_d;
  logic            mem_valid, mem_ready_go, misal, ld_ok, wb_cap;
  logic [XLEN-1:0] rdata_q, ld_data;

  assign misal = mem_is_load &&
                 (((mem_l_mask[LM_LH] || mem_l_mask[LM_LHU]) && mem_ls_addr_2low[0]) ||
                  (mem_l_mask[LM_LW] && (mem_ls_addr_2low != 2'b00)));
  assign ld_ok        = mem_is_load && !misal;
  assign mem_ready_go = !mem_is_load || misal || (state_q == ST_DONE);
  assign mem_wb_valid = mem_valid && mem_ready_go;
  // DRAIN blocks intake so a fresh load cannot race the stale response.
  assign mem_allowin  = (state_q != ST_DRAIN) && (!mem_valid || (mem_ready_go && wb_allowin));
  assign dbus_req     = (state_q == ST_REQ);
  assign dbus_addr    = {mem_alu_res[XLEN-1:2], 2'b00};
  assign wb_cap       = mem_wb_valid && wb_allowin && !pipe_flush;

  always_ff @(posedge clk) begin
    if (!rst_n)           mem_valid <= 1'b0;
    else if (pipe_flush)  mem_valid <= 1'b0;
    else if (mem_allowin) mem_valid <= ex_mem_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!pipe_flush && mem_valid && ld_ok) state_d = ST_REQ;
      ST_REQ: begin
        // A grant accepted alongside a flush still owes us a response.
        if (pipe_flush)    state_d = dbus_gnt ? ST_DRAIN : ST_IDLE;
        else if (dbus_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (dbus_rvalid)     state_d = pipe_flush ? ST_IDLE : ST_DONE;
        else if (pipe_flush) state_d = ST_DRAIN;
      end
      ST_DONE:  if (pipe_flush || (mem_wb_valid && wb_allowin)) state_d = ST_IDLE;
      ST_DRAIN: if (dbus_rvalid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      rdata_q <= '0;
    else if ((state_q == ST_WAIT) && dbus_rvalid && !pipe_flush)
      rdata_q <= dbus_rdata;
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .word      (rdata_q),
    .addr_2low (mem_ls_addr_2low),
    .l_mask    (mem_l_mask),
    .data      (ld_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_pc         <= '0;
      wb_wdata      <= '0;
      wb_req_rf     <= 1'b0;
      wb_rf_waddr   <= '0;
      wb_load_misal <= 1'b0;
    end else if (wb_cap) begin
      wb_pc         <= mem_pc;
      wb_wdata      <= ld_ok ? ld_data : mem_alu_res;
      wb_req_rf     <= mem_req_rf && !misal;
      wb_rf_waddr   <= mem_rf_waddr;
      wb_load_misal <= misal;
    end
  end
endmodule

// File: tb/tb_mem_load_stage.sv
// Directed bench for mem_load_stage: ALU pass-through, aligned/misaligned
// loads, bus and WB stalls, flushes in each FSM phase and mid-flight reset.
module tb_mem_load_stage;
  logic        clk = 1'b0;
  logic        rst_n, pipe_flush, ex_mem_valid, mem_allowin;
  logic [31:0] mem_pc, mem_alu_res;
  logic        mem_req_rf, mem_is_load;
  logic [4:0]  mem_rf_waddr, mem_l_mask;
  logic [1:0]  mem_ls_addr_2low;
  logic        dbus_req, dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_addr, dbus_rdata;
  logic        wb_allowin, mem_wb_valid, wb_req_rf, wb_load_misal;
  logic [31:0] wb_pc, wb_wdata;
  logic [4:0]  wb_rf_waddr;

  localparam logic [4:0] M_LB = 5'b00001, M_LH = 5'b00010, M_LW = 5'b00100,
                         M_LBU = 5'b01000, M_LHU = 5'b10000;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] last_pc;

  always #5 clk = ~clk;

  mem_load_stage #(.XLEN(32), .RF_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .pipe_flush(pipe_flush),
    .ex_mem_valid(ex_mem_valid), .mem_allowin(mem_allowin),
    .mem_pc(mem_pc), .mem_alu_res(mem_alu_res),
    .mem_req_rf(mem_req_rf), .mem_rf_waddr(mem_rf_waddr),
    .mem_is_load(mem_is_load), .mem_ls_addr_2low(mem_ls_addr_2low),
    .mem_l_mask(mem_l_mask),
    .dbus_req(dbus_req), .dbus_addr(dbus_addr),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .wb_allowin(wb_allowin), .mem_wb_valid(mem_wb_valid),
    .wb_pc(wb_pc), .wb_wdata(wb_wdata), .wb_req_rf(wb_req_rf),
    .wb_rf_waddr(wb_rf_waddr), .wb_load_misal(wb_load_misal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Present one instruction and let it be captured at the next edge.
  task automatic issue(input logic [31:0] pc, input logic [31:0] addr, input logic ld,
                       input logic [4:0] mask, input logic rf, input logic [4:0] wa);
    mem_pc = pc; mem_alu_res = addr; mem_ls_addr_2low = addr[1:0];
    mem_is_load = ld; mem_l_mask = mask; mem_req_rf = rf; mem_rf_waddr = wa;
    ex_mem_valid = 1'b1;
    step();
    ex_mem_valid = 1'b0;
  endtask

  task automatic do_load(input string nm, input logic [31:0] pc, input logic [31:0] addr,
                         input logic [4:0] mask, input logic [31:0] rdata,
                         input logic [31:0] exp, input int gnt_dly, input int wb_stall);
    issue(pc, addr, 1'b1, mask, 1'b1, 5'd9);
    settle();
    chk({nm, "_idle_req"}, 32'(dbus_req), 0);
    chk({nm, "_idle_allowin"}, 32'(mem_allowin), 0);
    step(); settle();
    for (int i = 0; i < gnt_dly; i++) begin
      chk({nm, "_req_hold"}, 32'(dbus_req), 1);
      chk({nm, "_req_allowin"}, 32'(mem_allowin), 0);
      step(); settle();
    end
    chk({nm, "_req"}, 32'(dbus_req), 1);
    chk({nm, "_addr"}, dbus_addr, {addr[31:2], 2'b00});
    dbus_gnt = 1'b1;
    step();
    dbus_gnt = 1'b0;
    settle();
    chk({nm, "_wait_req"}, 32'(dbus_req), 0);
    chk({nm, "_wait_wbv"}, 32'(mem_wb_valid), 0);
    dbus_rvalid = 1'b1; dbus_rdata = rdata;
    step();
    dbus_rvalid = 1'b0; dbus_rdata = 32'h0BAD_0BAD;
    for (int i = 0; i < wb_stall; i++) begin
      wb_allowin = 1'b0;
      settle();
      chk({nm, "_stall_wbv"}, 32'(mem_wb_valid), 1);
      chk({nm, "_stall_allowin"}, 32'(mem_allowin), 0);
      chk({nm, "_stall_hold_pc"}, wb_pc, last_pc);
      step();
    end
    wb_allowin = 1'b1;
    settle();
    chk({nm, "_done_wbv"}, 32'(mem_wb_valid), 1);
    chk({nm, "_done_allowin"}, 32'(mem_allowin), 1);
    step(); settle();
    chk({nm, "_wdata"}, wb_wdata, exp);
    chk({nm, "_wb_pc"}, wb_pc, pc);
    chk({nm, "_req_rf"}, 32'(wb_req_rf), 1);
    chk({nm, "_misal"}, 32'(wb_load_misal), 0);
    chk({nm, "_once"}, 32'(mem_wb_valid), 0);
    last_pc = pc;
  endtask

  task automatic chk_wb_zero(input string nm);
    chk({nm, "_wb_pc"}, wb_pc, 0);
    chk({nm, "_wb_wdata"}, wb_wdata, 0);
    chk({nm, "_wb_req_rf"}, 32'(wb_req_rf), 0);
    chk({nm, "_wb_waddr"}, 32'(wb_rf_waddr), 0);
    chk({nm, "_wb_misal"}, 32'(wb_load_misal), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pipe_flush = 1'b0; ex_mem_valid = 1'b0;
    mem_pc = '0; mem_alu_res = '0; mem_req_rf = 1'b0; mem_rf_waddr = '0;
    mem_is_load = 1'b0; mem_ls_addr_2low = '0; mem_l_mask = '0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0; wb_allowin = 1'b0;
    last_pc = '0;
    step(); step(); settle();
    chk("rst_dbus_req", 32'(dbus_req), 0);
    chk("rst_allowin", 32'(mem_allowin), 1);
    chk("rst_wbv", 32'(mem_wb_valid), 0);
    chk_wb_zero("rst");
    rst_n = 1'b1; wb_allowin = 1'b1;
    step();

    // ALU result passes straight through, no bus traffic
    issue(32'h40, 32'h1234, 1'b0, 5'b0, 1'b1, 5'd5);
    settle();
    chk("alu_wbv", 32'(mem_wb_valid), 1);
    chk("alu_dbus_req", 32'(dbus_req), 0);
    chk("alu_allowin", 32'(mem_allowin), 1);
    step(); settle();
    chk("alu_wdata", wb_wdata, 32'h1234);
    chk("alu_req_rf", 32'(wb_req_rf), 1);
    chk("alu_waddr", 32'(wb_rf_waddr), 5);
    chk("alu_wb_pc", wb_pc, 32'h40);
    chk("alu_misal", 32'(wb_load_misal), 0);
    chk("alu_once", 32'(mem_wb_valid), 0);
    last_pc = 32'h40;

    do_load("lb",  32'h44, 32'h103, M_LB,  32'h80FF_FFFF, 32'hFFFF_FF80, 0, 0);
    do_load("lhu", 32'h48, 32'h102, M_LHU, 32'hBEEF_0000, 32'h0000_BEEF, 0, 0);
    do_load("lh",  32'h4C, 32'h100, M_LH,  32'h1234_8001, 32'hFFFF_8001, 0, 0);
    do_load("lbu", 32'h50, 32'h101, M_LBU, 32'h0000_A500, 32'h0000_00A5, 0, 0);
    do_load("lw",  32'h54, 32'h104, M_LW,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);

    // Misaligned loads retire in one cycle without touching the bus
    issue(32'h60, 32'h102, 1'b1, M_LW, 1'b1, 5'd3);
    settle();
    chk("mis_lw_wbv", 32'(mem_wb_valid), 1);
    chk("mis_lw_dbus_req", 32'(dbus_req), 0);
    step(); settle();
    chk("mis_lw_flag", 32'(wb_load_misal), 1);
    chk("mis_lw_req_rf", 32'(wb_req_rf), 0);
    chk("mis_lw_wdata", wb_wdata, 32'h102);
    chk("mis_lw_dbus_req2", 32'(dbus_req), 0);
    issue(32'h64, 32'h101, 1'b1, M_LHU, 1'b1, 5'd3);
    settle();
    chk("mis_lhu_dbus_req", 32'(dbus_req), 0);
    step(); settle();
    chk("mis_lhu_flag", 32'(wb_load_misal), 1);
    chk("mis_lhu_wb_pc", wb_pc, 32'h64);
    chk("mis_lhu_dbus_req2", 32'(dbus_req), 0);
    last_pc = 32'h64;

    // Grant held off 3 cycles, WB back-pressure 2 cycles in DONE
    do_load("stall", 32'h68, 32'h108, M_LW, 32'hCAFE_F00D, 32'hCAFE_F00D, 3, 2);

    // Flush in WAIT: response arrives 4 cycles later and is dropped
    issue(32'h70, 32'h200, 1'b1, M_LW, 1'b1, 5'd6);
    step(); settle();
    dbus_gnt = 1'b1;
    step();
    dbus_gnt = 1'b0;
    pipe_flush = 1'b1;
    settle();
    step();
    pipe_flush = 1'b0;
    mem_pc = 32'h80; mem_alu_res = 32'h5A5A; mem_is_load = 1'b0;
    mem_req_rf = 1'b1; mem_rf_waddr = 5'd4; ex_mem_valid = 1'b1;
    settle();
    for (int i = 0; i < 3; i++) begin
      chk("drain_allowin", 32'(mem_allowin), 0);
      chk("drain_wbv", 32'(mem_wb_valid), 0);
      chk("drain_dbus_req", 32'(dbus_req), 0);
      step(); settle();
    end
    dbus_rvalid = 1'b1; dbus_rdata = 32'h1234_5678;
    settle();
    chk("drain_rv_allowin", 32'(mem_allowin), 0);
    step();
    dbus_rvalid = 1'b0;
    settle();
    chk("drain_idle_allowin", 32'(mem_allowin), 1);
    chk("drain_idle_wbv", 32'(mem_wb_valid), 0);
    chk("drain_discard_pc", wb_pc, last_pc);
    step();
    ex_mem_valid = 1'b0;
    settle();
    chk("post_drain_wbv", 32'(mem_wb_valid), 1);
    step(); settle();
    chk("post_drain_wdata", wb_wdata, 32'h5A5A);
    chk("post_drain_pc", wb_pc, 32'h80);
    last_pc = 32'h80;

    // Flush in REQ without grant: straight back to IDLE
    issue(32'h90, 32'h300, 1'b1, M_LW, 1'b1, 5'd2);
    step(); settle();
    chk("fl_req_req", 32'(dbus_req), 1);
    pipe_flush = 1'b1;
    step();
    pipe_flush = 1'b0;
    settle();
    chk("fl_req_dbus_req", 32'(dbus_req), 0);
    chk("fl_req_allowin", 32'(mem_allowin), 1);
    chk("fl_req_wbv", 32'(mem_wb_valid), 0);
    step(); settle();
    chk("fl_req_stay_idle", 32'(dbus_req), 0);

    // Flush in REQ with grant the same cycle: must drain the response
    issue(32'h94, 32'h304, 1'b1, M_LW, 1'b1, 5'd2);
    step();
    dbus_gnt = 1'b1; pipe_flush = 1'b1;
    step();
    dbus_gnt = 1'b0; pipe_flush = 1'b0;
    settle();
    chk("fl_gnt_allowin", 32'(mem_allowin), 0);
    chk("fl_gnt_dbus_req", 32'(dbus_req), 0);
    dbus_rvalid = 1'b1;
    step();
    dbus_rvalid = 1'b0;
    settle();
    chk("fl_gnt_idle_allowin", 32'(mem_allowin), 1);
    chk("fl_gnt_discard_pc", wb_pc, last_pc);

    // Reset in WAIT abandons the transaction
    issue(32'hA0, 32'h400, 1'b1, M_LW, 1'b1, 5'd1);
    step();
    dbus_gnt = 1'b1;
    step();
    dbus_gnt = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    settle();
    chk("mid_rst_dbus_req", 32'(dbus_req), 0);
    chk("mid_rst_allowin", 32'(mem_allowin), 1);
    chk("mid_rst_wbv", 32'(mem_wb_valid), 0);
    chk_wb_zero("mid_rst");
    last_pc = '0;
    do_load("after_rst", 32'hB0, 32'h10C, M_LB, 32'h0000_7F00, 32'h0000_0000, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_load_stage.md
MEM_LOAD_STAGE -- requirements
Module: mem_load_stage

Interface
REQ-001 Parameters SHALL be: XLEN, default 32, datapath width; RF_ADDR_WIDTH, default 5, register-file address width.
REQ-002 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 pipe_flush  in  1  kill the in-flight MEM instruction and the WB outputs.
REQ-005 ex_mem_valid  in  1  the EX->MEM register holds a valid instruction ready to enter MEM.
REQ-006 mem_allowin  out  1  MEM accepts a new instruction this cycle.
REQ-007 mem_pc, mem_alu_res  in  XLEN  instruction PC and ALU result (the load address for loads).
REQ-008 mem_req_rf  in  1 and mem_rf_waddr  in  RF_ADDR_WIDTH  register write request and destination.
REQ-009 mem_is_load  in  1 and mem_ls_addr_2low  in  2 and mem_l_mask  in  5  load qualifiers; l_mask is one-hot with bit0 LB, bit1 LH, bit2 LW, bit3 LBU, bit4 LHU.
REQ-010 dbus_req  out  1 and dbus_addr  out  XLEN  data-bus read request; dbus_addr SHALL be word-aligned.
REQ-011 dbus_gnt  in  1 and dbus_rvalid  in  1 and dbus_rdata  in  XLEN  bus grant, response valid and read data.
REQ-012 wb_allowin  in  1  WB accepts data; mem_wb_valid  out  1  MEM offers a valid result.
REQ-013 wb_pc, wb_wdata  out  XLEN and wb_req_rf  out  1 and wb_rf_waddr  out  RF_ADDR_WIDTH and wb_load_misal  out  1  are the registered WB-stage outputs.

Function
REQ-014 An internal mem_valid register SHALL load ex_mem_valid whenever mem_allowin=1, and SHALL clear on pipe_flush.
REQ-015 mem_allowin SHALL equal !mem_valid || (mem_ready_go && wb_allowin), and SHALL be 0 while in DRAIN.
REQ-016 mem_ready_go SHALL be 1 when: the instruction is not a load, the load is misaligned, or the FSM is in DONE.
REQ-017 Misalignment SHALL be flagged for LH/LHU with addr[0]=1 and for LW with addr[1:0]!=0; a misaligned load SHALL issue no bus request.
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, DONE and DRAIN.
REQ-019 FSM transitions SHALL be: IDLE->REQ when mem_valid holds an aligned load; REQ->WAIT on dbus_gnt; WAIT->DONE on dbus_rvalid, capturing dbus_rdata; DONE->IDLE when mem_wb_valid && wb_allowin.
REQ-020 dbus_req SHALL be 1 only in REQ; dbus_addr SHALL be {mem_alu_res[XLEN-1:2],2'b00}.
REQ-021 Load data SHALL be extracted from the captured word: the byte lane is selected by addr_2low and the halfword by addr_2low[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
REQ-022 mem_wb_valid SHALL equal mem_valid && mem_ready_go.
REQ-023 The WB registers SHALL capture on mem_wb_valid && wb_allowin; wb_wdata SHALL be the extracted load data for aligned loads and mem_alu_res otherwise.
REQ-024 A misaligned load SHALL set wb_load_misal=1 and force wb_req_rf=0.
REQ-025 When the WB registers do not capture, they SHALL hold their values.
REQ-026 Flush in IDLE, DONE, or REQ without gnt SHALL send the FSM to IDLE with dbus_req=0 the next cycle.
REQ-027 Flush in WAIT, or in REQ with gnt the same cycle, SHALL send the FSM to DRAIN.
REQ-028 DRAIN SHALL discard the response and go to IDLE on dbus_rvalid; at most one transaction is outstanding.
REQ-029 pipe_flush SHALL take priority over every capture.
REQ-030 Minimum load latency SHALL be: capture at cycle 0, REQ at 1, gnt at 1, rvalid at 2, DONE with mem_wb_valid at 3.

Reset
REQ-031 With rst_n=0 at a clock edge: mem_valid=0, FSM=IDLE, dbus_req=0, captured data=0.
REQ-032 With rst_n=0 at a clock edge: every wb_* output and wb_load_misal SHALL be 0.
REQ-033 Reset asserted mid-transaction SHALL abandon it; the bus agent is reset with the core.

Structure
REQ-034 The FSM state encoding and the l_mask bit positions SHALL reside in the shared defines package alongside XLEN and RF_ADDR_WIDTH.
REQ-035 Load-data alignment/extension SHALL be a combinational sub-module named load_align.

Verification
REQ-036 ALU op: mem_alu_res=0x1234, req_rf=1, wb_allowin=1 -> next cycle mem_wb_valid=1 and wb_wdata=0x1234, with no dbus_req.
REQ-037 LB at addr 0x103, rdata=0x80FF_FFFF, gnt and rvalid immediate -> wb_wdata=0xFFFF_FF80 at cycle 3, dbus_addr=0x100.
REQ-038 LHU at addr 0x102, rdata=0xBEEF_0000 -> wb_wdata=0x0000_BEEF.
REQ-038 (cont.) LW at addr 0x102 -> wb_load_misal=1, wb_req_rf=0, dbus_req never asserted.
REQ-039 Load with gnt delayed 3 cycles and wb_allowin=0 for 2 cycles in DONE -> dbus_req is held, mem_allowin=0 throughout, and data is delivered once.
REQ-040 pipe_flush in WAIT, then rvalid 4 cycles later -> FSM stays in DRAIN, mem_allowin=0, response discarded, mem_wb_valid=0, then IDLE.
